// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes.
// A fix-up cycle applies signs, then the result is shown for one cycle with valid_o.
module riscv_mdu #(
  parameter int WORD_WIDTH   = 32,
  parameter int MDU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  output logic                    ready_o,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
  input  logic [WORD_WIDTH-1:0]   op_a_i,
  input  logic [WORD_WIDTH-1:0]   op_b_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  output logic [WORD_WIDTH-1:0]   result_o,
  output logic                    busy_o
);

  localparam int W     = WORD_WIDTH;
  localparam int CNT_W = $clog2(WORD_WIDTH);

  localparam logic [MDU_OP_WIDTH-1:0] OP_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] OP_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] OP_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] OP_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] OP_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] OP_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] OP_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] OP_REMU   = 3'b111;

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  // Handshake: a request is taken at a rising edge when en_i & ready_o & ~flush_i;
  // valid_o is a single-cycle pulse with result_o, and nothing waits on a consumer.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                    state, state_next;
  logic [MDU_OP_WIDTH-1:0]   op_q;
  logic [W-1:0]              operand_q;
  logic [2*W-1:0]            acc_q;
  logic                      neg_q;
  logic                      rem_neg_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [W-1:0]              result_q;

  logic                      accept;
  logic                      is_div_in;
  logic                      a_signed_in, b_signed_in;
  logic                      a_neg_in, b_neg_in;
  logic [W-1:0]              a_mag_in, b_mag_in;
  logic                      div_zero, div_ovf, special;
  logic [W-1:0]              special_result;

  logic [W:0]                mul_sum;
  logic [2*W-1:0]            mul_next;
  logic [W:0]                div_shift;
  logic                      div_ge;
  logic [W-1:0]              div_diff;
  logic [2*W-1:0]            div_next;

  logic [2*W-1:0]            prod;
  logic [W-1:0]              quot;
  logic [W-1:0]              remv;
  logic [W-1:0]              fix_result;

  // Operand decode straight from the request inputs, used only at the accepting edge.
  always_comb begin
    accept         = en_i & ready_o & ~flush_i;
    is_div_in      = mdu_op_i[2];
    a_signed_in    = mdu_op_i[2] ? ~mdu_op_i[0] : (mdu_op_i[1:0] != 2'b11);
    b_signed_in    = mdu_op_i[2] ? ~mdu_op_i[0] : ~mdu_op_i[1];
    a_neg_in       = a_signed_in & op_a_i[W-1];
    b_neg_in       = b_signed_in & op_b_i[W-1];
    a_mag_in       = a_neg_in ? -op_a_i : op_a_i;
    b_mag_in       = b_neg_in ? -op_b_i : op_b_i;
    div_zero       = is_div_in & (op_b_i == '0);
    div_ovf        = is_div_in & ~mdu_op_i[0] & (op_a_i == MIN_INT) & (op_b_i == '1);
    special        = div_zero | div_ovf;
    special_result = mdu_op_i[1] ? (div_zero ? op_a_i : '0) : (div_zero ? '1 : MIN_INT);
  end

  // Multiply keeps the multiplier in acc low half and shifts the partial sum in from the top.
  // Divide keeps the dividend in acc low half; quotient bits shift in as dividend bits shift out.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = div_shift >= {1'b0, operand_q};
    div_diff  = div_shift[W-1:0] - operand_q;
    div_next  = {(div_ge ? div_diff : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    remv = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    case (op_q)
      OP_MUL:                      fix_result = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*W-1:W];
      OP_DIV, OP_DIVU:             fix_result = quot;
      OP_REM, OP_REMU:             fix_result = remv;
      default:                     fix_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (flush_i) state_next = IDLE;
            else if (cnt_q == '0) state_next = FIX;
      FIX:  state_next = flush_i ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state == IDLE);
    busy_o   = (state == CALC) | (state == FIX);
    valid_o  = (state == DONE) & ~flush_i;
    result_o = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= mdu_op_i;
        operand_q <= is_div_in ? b_mag_in : a_mag_in;
        acc_q     <= {{W{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
        neg_q     <= a_neg_in ^ b_neg_in;
        rem_neg_q <= a_neg_in;
        cnt_q     <= CNT_W'(W - 1);
        if (special) result_q <= special_result;
      end else if (state == CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q - 1'b1;
      end else if (state == FIX && !flush_i) begin
        result_q <= fix_result;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// Bench for riscv_mdu: vector table plus random ops through a result queue,
// then hand-written flush, reset and continuous-request sequences.
module tb_riscv_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        flush_i;
  logic [2:0]  mdu_op_i;
  logic [31:0] op_a_i, op_b_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] result_o;

  riscv_mdu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .ready_o  (ready_o),
    .mdu_op_i (mdu_op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h, expected no valid", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    ref_model = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); ref_model = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); ref_model = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); ref_model = p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; ref_model = pu[63:32]; end
      3'd4: if (b == 0) ref_model = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_model = 32'h80000000;
            else ref_model = ia / ib;
      3'd5: ref_model = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) ref_model = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_model = 32'h0;
            else ref_model = ia % ib;
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      next_cycle();
      n++;
    end
    check("ready_wait", {31'b0, ready_o}, 32'd1);
  endtask

  // Issue one op, scramble the inputs after acceptance, then check latency and ready timing.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   k;
    logic rdy_seen;
    wait_ready();
    mdu_op_i = op;
    op_a_i   = a;
    op_b_i   = b;
    en_i     = 1'b1;
    exp_q.push_back(exp);
    last_result = exp;
    next_cycle();
    en_i     = 1'b0;
    op_a_i   = $urandom;
    op_b_i   = $urandom;
    mdu_op_i = 3'($urandom_range(0, 7));
    k        = 1;
    rdy_seen = 1'b0;
    while (!valid_o && k < 60) begin
      if (ready_o) rdy_seen = 1'b1;
      next_cycle();
      k++;
    end
    if (ready_o) rdy_seen = 1'b1;
    check({name, "_latency"}, 32'(k), 32'(lat));
    check({name, "_ready_low"}, {31'b0, rdy_seen}, 32'd0);
    next_cycle();
    check({name, "_ready_back"}, {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat, vc, accepts, last_acc;
    logic        gaps_ok;

    en_i = 1'b0; flush_i = 1'b0; mdu_op_i = '0; op_a_i = '0; op_b_i = '0;
    rst_n = 1'b1;
    last_result = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[3]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,        32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};

    for (int i = 0; i < 12; i++)
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      lat = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 34;
      issue($sformatf("rand%0d", i), op, a, b, ref_model(op, a, b), lat);
    end

    // Flush a DIV in its tenth cycle: no result may appear and result_o must hold.
    wait_ready();
    mdu_op_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd7; en_i = 1'b1;
    next_cycle();
    en_i = 1'b0;
    repeat (9) next_cycle();
    check("flush_busy_before", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    check("flush_ready", {31'b0, ready_o}, 32'd1);
    check("flush_busy_after", {31'b0, busy_o}, 32'd0);
    vc = valid_cnt;
    repeat (40) next_cycle();
    check("flush_no_valid", 32'(valid_cnt), 32'(vc));
    check("flush_result_hold", result_o, last_result);
    issue("after_flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    // Reset in cycle 20 of a MUL.
    wait_ready();
    mdu_op_i = 3'd0; op_a_i = 32'h1234; op_b_i = 32'h5678; en_i = 1'b1;
    next_cycle();
    en_i = 1'b0;
    repeat (19) next_cycle();
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
    check("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    last_result = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    vc = valid_cnt;
    repeat (40) next_cycle();
    check("rst_no_valid", 32'(valid_cnt), 32'(vc));
    check("rst_result_zero", result_o, 32'd0);

    // en_i held high: exactly one acceptance every 35 cycles.
    wait_ready();
    mdu_op_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7; en_i = 1'b1;
    accepts = 0; last_acc = 0; gaps_ok = 1'b1;
    for (int cyc = 0; cyc < 106; cyc++) begin
      if (ready_o && en_i) begin
        exp_q.push_back(32'd14);
        if (accepts > 0 && cyc - last_acc != 35) gaps_ok = 1'b0;
        last_acc = cyc;
        accepts++;
      end
      next_cycle();
    end
    en_i = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd4);
    check("hold_gaps", {31'b0, gaps_ok}, 32'd1);
    repeat (40) next_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
